wb_la_master: RTL and testbench
===============================

WB_LA_MASTER -- requirements
Module: wb_la_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles without wbm_ack_i before an access aborts; legal range 1..65535.
REQ-002 SHALL have ports; clock and reset first:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- active_i  in  1  block enable.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_sel_i  in  4  byte selects.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data; 0 for writes and timeouts.
- rsp_err_o  out  1  timeout flag.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
- wbm_sel_o  out  4, wbm_adr_o  out  32, wbm_dat_o  out  32  Wishbone master payload.
- wbm_ack_i  in  1, wbm_dat_i  in  32  slave response.

Function
REQ-003 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE, one access outstanding at most.
REQ-004 IDLE: cmd_ready_o = active_i; a handshake registers we/sel/adr/dat and enters BUS next cycle.
REQ-005 BUS: wbm_cyc_o = wbm_stb_o = 1; wbm_we/sel/adr/dat_o hold the registered command, stable until exit.
REQ-006 In BUS, wbm_ack_i sampled high SHALL deassert cyc/stb the next cycle, capture wbm_dat_i if read (0 if write), rsp_err_o = 0, enter RESP.
REQ-007 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack; at count = TIMEOUT_CYCLES-1 with no ack, exit BUS to RESP with rsp_err_o = 1, rsp_dat_o = 0.
REQ-008 Ack and timeout in the same cycle: ack SHALL win (rsp_err_o = 0).
REQ-009 RESP: rsp_valid_o = 1 with rsp_dat_o/rsp_err_o stable; rsp_valid_o & rsp_ready_i returns to IDLE next cycle.
REQ-010 cmd_ready_o SHALL be 0 outside IDLE; rsp_valid_o SHALL be 0 outside RESP; cyc/stb SHALL be 0 outside BUS.
REQ-011 Minimum command-to-response latency: handshake at cycle N, BUS at N+1, ack at N+1 gives rsp_valid_o at N+2.
REQ-012 active_i low SHALL block new commands only; an access already in progress completes normally.
REQ-013 wbm_ack_i in IDLE or RESP SHALL be ignored.
REQ-014 Timeout counter width SHALL be 16 bits; the counter SHALL NOT wrap.

Reset
REQ-015 Reset low SHALL asynchronously force IDLE; all outputs 0 except cmd_ready_o, which follows active_i once in IDLE.
REQ-016 Reset during BUS SHALL drop cyc/stb immediately and discard the pending response.
REQ-017 Reset release SHALL be synchronised by the integrator; the block does not add a reset synchroniser.

Structure
REQ-018 Shared package wb_pkg SHALL hold the FSM state enum (IDLE, BUS, RESP), WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4.
REQ-019 Sub-module wb_timeout_cnt (clear, enable, terminal-count output) SHALL implement the timeout; all other logic is flat.

Verification
REQ-020 Write adr 0x3000_0004, dat 0xDEAD_BEEF, sel 0xF; slave acks 2 cycles after stb -> one cyc/stb assertion 3 cycles long with those values, we = 1; then rsp_valid_o with rsp_dat_o 0, rsp_err_o 0.
REQ-021 Read adr 0x3000_0000; slave acks same cycle with 0x1234_5678 -> rsp_dat_o 0x1234_5678 two cycles after the command handshake.
REQ-022 TIMEOUT_CYCLES = 8, slave never acks -> stb high exactly 8 cycles, then rsp_err_o 1, rsp_dat_o 0.
REQ-023 TIMEOUT_CYCLES = 8, ack in the 8th BUS cycle -> rsp_err_o 0 with valid data.
REQ-024 Hold rsp_ready_i low 5 cycles -> rsp_valid_o and response stay stable, cmd_ready_o stays 0; then a new command is accepted the cycle after the response handshake.
REQ-025 Assert wb_rst_ni low mid-BUS -> cyc/stb 0 the same cycle; after release, IDLE with no stale rsp_valid_o.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the access-sequencer state encoding
// for the wb_la_master slice.
package wb_pkg;
   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_e;
endpackage

// File: rtl/wb_timeout_cnt.sv
// 16-bit saturating bus-cycle counter; tc_o flags that the access has
// spent TIMEOUT_CYCLES cycles on the bus, counting the current one.
module wb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_VAL);
endmodule

// File: rtl/wb_la_master.sv
// Single-outstanding Wishbone classic master: turns a valid/ready command
// into one bus access and returns the read data or a timeout via valid/ready.
module wb_la_master
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                active_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [WB_SEL_W-1:0] cmd_sel_i,
   input  logic [WB_ADR_W-1:0] cmd_adr_i,
   input  logic [WB_DAT_W-1:0] cmd_dat_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [WB_DAT_W-1:0] rsp_dat_o,
   output logic                rsp_err_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [WB_SEL_W-1:0] wbm_sel_o,
   output logic [WB_ADR_W-1:0] wbm_adr_o,
   output logic [WB_DAT_W-1:0] wbm_dat_o,
   input  logic                wbm_ack_i,
   input  logic [WB_DAT_W-1:0] wbm_dat_i
);
   wb_state_e           state_q;
   logic                we_q;
   logic [WB_SEL_W-1:0] sel_q;
   logic [WB_ADR_W-1:0] adr_q;
   logic [WB_DAT_W-1:0] dat_q;
   logic [WB_DAT_W-1:0] rsp_dat_q;
   logic                rsp_err_q;
   logic                cmd_hs;
   logic                tmo_tc;

   assign cmd_ready_o = (state_q == IDLE) && active_i;
   assign cmd_hs      = cmd_valid_i && cmd_ready_o;

   wb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rst_ni),
      .clr_i (cmd_hs),
      .en_i  ((state_q == BUS) && !wbm_ack_i),
      .tc_o  (tmo_tc)
   );

   // Ack is tested before the terminal count so a late ack still wins.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_hs) begin
                  we_q    <= cmd_we_i;
                  sel_q   <= cmd_sel_i;
                  adr_q   <= cmd_adr_i;
                  dat_q   <= cmd_dat_i;
                  state_q <= BUS;
               end
            end
            BUS: begin
               if (wbm_ack_i) begin
                  rsp_dat_q <= we_q ? '0 : wbm_dat_i;
                  rsp_err_q <= 1'b0;
                  state_q   <= RESP;
               end else if (tmo_tc) begin
                  rsp_dat_q <= '0;
                  rsp_err_q <= 1'b1;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wbm_cyc_o   = (state_q == BUS);
   assign wbm_stb_o   = (state_q == BUS);
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_wb_la_master.sv
// Directed bench for wb_la_master with an 8-cycle timeout and a
// cycle-scripted slave ack.
module tb_wb_la_master;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        active_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [3:0]  cmd_sel_i;
   logic [31:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] JUNK = 32'hBAD0_0BAD;

   wb_la_master #(.TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .active_i   (active_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i   (cmd_we_i),
      .cmd_sel_i  (cmd_sel_i),
      .cmd_adr_i  (cmd_adr_i),
      .cmd_dat_i  (cmd_dat_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o  (rsp_dat_o),
      .rsp_err_o  (rsp_err_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_dat_i  (wbm_dat_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one command, then plays the slave: ack in BUS cycle ack_at
   // (0 = never). Reports stb length and whether payload held steady.
   task automatic do_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int ack_at, input logic [31:0] ack_dat,
                         output int stb_len, output bit payload_ok);
      stb_len    = 0;
      payload_ok = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_sel_i   = sel;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      tick();
      cmd_valid_i = 1'b0;
      cmd_dat_i   = JUNK;
      cmd_adr_i   = JUNK;
      for (int c = 1; c <= 40 && wbm_stb_o === 1'b1; c++) begin
         stb_len++;
         if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_sel_o !== sel ||
             wbm_adr_o !== adr || wbm_dat_o !== dat)
            payload_ok = 1'b0;
         wbm_ack_i = (c == ack_at);
         wbm_dat_i = (c == ack_at) ? ack_dat : JUNK;
         tick();
      end
      wbm_ack_i = 1'b0;
      wbm_dat_i = JUNK;
   endtask

   task automatic rsp_handshake();
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
          rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0 || wbm_adr_o !== 32'h0 || wbm_we_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: cyc=%b stb=%b rv=%b err=%b dat=%h adr=%h, required all 0",
                  wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o, rsp_dat_o, wbm_adr_o);
      end
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready_o);
      end
      active_i = 1'b0;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_inactive: got %b, required 0", cmd_ready_o);
      end
      active_i = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      $display("reset: released, cmd_ready=%b", cmd_ready_o);
   endtask

   task automatic test_write();
      int len;
      bit ok;
      do_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 3, JUNK, len, ok);
      $display("write: adr=30000004 dat=DEADBEEF stb_len=%0d", len);
      checks++;
      if (len !== 3) begin
         errors++;
         $display("FAIL write_stb_len: got %0d, required 3", len);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL write_payload: bus controls/payload not held, required we=1 sel=F adr=30000004 dat=DEADBEEF");
      end
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0 || rsp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL write_rsp: rv=%b dat=%h err=%b, required rv=1 dat=0 err=0",
                  rsp_valid_o, rsp_dat_o, rsp_err_o);
      end
      rsp_handshake();
   endtask

   task automatic test_read();
      int len;
      bit ok;
      do_cmd(1'b0, 4'hF, 32'h3000_0000, JUNK, 1, 32'h1234_5678, len, ok);
      $display("read: adr=30000000 rsp_dat=%h stb_len=%0d", rsp_dat_o, len);
      checks++;
      if (len !== 1 || rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL read_latency: stb_len=%0d rv=%b, required stb_len=1 rv=1 two cycles after handshake",
                  len, rsp_valid_o);
      end
      checks++;
      if (rsp_dat_o !== 32'h1234_5678 || rsp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL read_data: dat=%h err=%b, required 12345678 err=0", rsp_dat_o, rsp_err_o);
      end
      rsp_handshake();
   endtask

   task automatic test_timeout();
      int len;
      bit ok;
      do_cmd(1'b0, 4'h3, 32'h4000_0010, JUNK, 0, JUNK, len, ok);
      $display("timeout: stb_len=%0d err=%b dat=%h", len, rsp_err_o, rsp_dat_o);
      checks++;
      if (len !== 8) begin
         errors++;
         $display("FAIL timeout_stb_len: got %0d, required 8", len);
      end
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL timeout_rsp: rv=%b err=%b dat=%h, required rv=1 err=1 dat=0",
                  rsp_valid_o, rsp_err_o, rsp_dat_o);
      end
      rsp_handshake();
   endtask

   task automatic test_ack_at_timeout();
      int len;
      bit ok;
      do_cmd(1'b0, 4'hC, 32'h4000_0020, JUNK, 8, 32'hA5A5_0008, len, ok);
      $display("ack_at_timeout: stb_len=%0d err=%b dat=%h", len, rsp_err_o, rsp_dat_o);
      checks++;
      if (len !== 8) begin
         errors++;
         $display("FAIL ack_tc_stb_len: got %0d, required 8", len);
      end
      checks++;
      if (rsp_err_o !== 1'b0 || rsp_dat_o !== 32'hA5A5_0008) begin
         errors++;
         $display("FAIL ack_tc_rsp: err=%b dat=%h, required err=0 dat=A5A50008", rsp_err_o, rsp_dat_o);
      end
      rsp_handshake();
   endtask

   task automatic test_back_to_back();
      int len;
      bit ok;
      bit stable = 1'b1;
      do_cmd(1'b0, 4'hF, 32'h3000_0008, JUNK, 2, 32'hCAFE_F00D, len, ok);
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wbm_ack_i = (i == 2);
         if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hCAFE_F00D || rsp_err_o !== 1'b0 ||
             cmd_ready_o !== 1'b0 || wbm_stb_o !== 1'b0)
            stable = 1'b0;
         tick();
      end
      wbm_ack_i = 1'b0;
      $display("backpressure: held 5 cycles, rsp_dat=%h", rsp_dat_o);
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL backpressure_hold: response or ready moved, required rv=1 dat=CAFEF00D err=0 ready=0 stb=0");
      end
      rsp_handshake();
      checks++;
      if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_ready: ready=%b rv=%b, required ready=1 rv=0", cmd_ready_o, rsp_valid_o);
      end
      do_cmd(1'b1, 4'h1, 32'h3000_000C, 32'h0000_00EE, 2, JUNK, len, ok);
      $display("back_to_back: write stb_len=%0d", len);
      checks++;
      if (len !== 2 || !ok || rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back_access: stb_len=%0d ok=%b rv=%b, required 2 1 1", len, ok, rsp_valid_o);
      end
      rsp_handshake();
   endtask

   task automatic test_inactive();
      bit idle_ok = 1'b1;
      active_i    = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_adr_i   = 32'h5000_0000;
      for (int i = 0; i < 3; i++) begin
         wbm_ack_i = 1'b1;
         tick();
         if (cmd_ready_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0)
            idle_ok = 1'b0;
      end
      wbm_ack_i = 1'b0;
      checks++;
      if (!idle_ok) begin
         errors++;
         $display("FAIL inactive_block: command accepted or ack not ignored, required ready=0 stb=0 rv=0");
      end
      active_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      active_i    = 1'b0;
      tick();
      tick();
      checks++;
      if (wbm_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL inactive_inflight: stb=%b, required 1 after active drop", wbm_stb_o);
      end
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h0BAD_CAFE;
      tick();
      wbm_ack_i = 1'b0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0BAD_CAFE) begin
         errors++;
         $display("FAIL inactive_complete: rv=%b dat=%h, required rv=1 dat=0BADCAFE", rsp_valid_o, rsp_dat_o);
      end
      rsp_handshake();
      checks++;
      if (cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL inactive_idle: ready=%b rv=%b, required 0 0", cmd_ready_o, rsp_valid_o);
      end
      $display("inactive: access completed with active_i low");
      active_i = 1'b1;
   endtask

   task automatic test_reset_mid_bus();
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_adr_i   = 32'h6000_0000;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      checks++;
      if (wbm_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_bus_entry: stb=%b, required 1", wbm_stb_o);
      end
      #2;
      rst_n     = 1'b0;
      wbm_ack_i = 1'b1;
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_bus: cyc=%b stb=%b, required 0 0 before next edge", wbm_cyc_o, wbm_stb_o);
      end
      tick();
      wbm_ack_i = 1'b0;
      rst_n     = 1'b1;
      tick();
      tick();
      checks++;
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wbm_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_release: rv=%b ready=%b stb=%b, required 0 1 0", rsp_valid_o, cmd_ready_o, wbm_stb_o);
      end
      $display("reset_mid_bus: access discarded");
   endtask

   initial begin
      rst_n       = 1'b0;
      active_i    = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_sel_i   = 4'h0;
      cmd_adr_i   = 32'h0;
      cmd_dat_i   = 32'h0;
      rsp_ready_i = 1'b0;
      wbm_ack_i   = 1'b0;
      wbm_dat_i   = JUNK;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_ack_at_timeout();
      test_back_to_back();
      test_inactive();
      test_reset_mid_bus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
